// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and default width for the multiply/divide unit
package mdu_pkg;

  localparam int MDU_W = 32;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - combinational conditional two's-complement negate
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = en ? -x : x;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mdu_state_e         state;
  logic               is_div_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   a_raw;
  logic               sign_q;
  logic               sign_r;
  logic               div0_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               in_signed;
  logic               in_is_div;
  logic               s_a;
  logic               s_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign in_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign in_is_div = (op == MDU_DIVU) || (op == MDU_DIV);
  assign s_a       = in_signed & dataA[WIDTH-1];
  assign s_b       = in_signed & dataB[WIDTH-1];

  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (.en(s_a), .x(dataA), .y(mag_a));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (.en(s_b), .x(dataB), .y(mag_b));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});

  // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, b_mag};
  assign q_bit    = ~rem_diff[WIDTH];
  assign rem_next = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.en(sign_q), .x(acc), .y(prod_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_quo (.en(sign_q), .x(acc[WIDTH-1:0]), .y(quo_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_rem (.en(sign_r), .x(acc[2*WIDTH-1:WIDTH]), .y(rem_fix));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      is_div_q    <= 1'b0;
      a_mag       <= '0;
      b_mag       <= '0;
      a_raw       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div0_q      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            is_div_q <= in_is_div;
            a_mag    <= mag_a;
            b_mag    <= mag_b;
            a_raw    <= dataA;
            sign_q   <= s_a ^ s_b;
            sign_r   <= s_a;
            div0_q   <= in_is_div && (dataB == '0);
            acc      <= {{WIDTH{1'b0}}, (in_is_div ? mag_a : mag_b)};
            cnt      <= '0;
            state    <= ST_CALC;
            busy     <= 1'b1;
          end else if (!start) begin
            if (hi_we) hi_out <= wd;
            if (lo_we) lo_out <= wd;
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= is_div_q ? {rem_next, acc[WIDTH-2:0], q_bit} : {mul_sum, acc[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
            if (cnt == LAST_STEP) state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done        <= 1'b1;
            div_by_zero <= div0_q;
            if (div0_q) begin
              hi_out <= a_raw;
              lo_out <= '1;
            end else if (is_div_q) begin
              hi_out <= rem_fix;
              lo_out <= quo_fix;
            end else begin
              hi_out <= prod_fix[2*WIDTH-1:WIDTH];
              lo_out <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wd = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_pass = 0;
  int n_total = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dataA(dataA), .dataB(dataB),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge following the launch edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; dataA = a; dataB = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic ediv0);
    int cyc;
    int busy_n;
    launch(o, a, b);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    cyc = 0;
    busy_n = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!done && busy) busy_n++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd33);
    check({tag, "_busy_span"}, 32'(busy_n), 32'd32);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi_out, ehi);
    check({tag, "_lo"}, lo_out, elo);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ediv0));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_n3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_n7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7dn2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu_5d0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div_n5d0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    hi_we = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi_out, 32'h0000_1234);
    check("mthi_lo_kept", lo_out, 32'h8000_0000);
    lo_we = 1'b1; wd = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", lo_out, 32'h0000_5678);

    // start with MTHI in the same idle cycle: the MT write is dropped
    hi_we = 1'b1; wd = 32'hDEAD_BEEF;
    run_op("start_vs_mthi", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    hi_we = 1'b0;

    // second start and MTHI mid-op are ignored
    launch(2'b10, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; dataA = 32'd6; dataB = 32'd7; hi_we = 1'b1; wd = 32'hABCD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    dones = 0; cap_hi = '0; cap_lo = '0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        cap_hi = hi_out;
        cap_lo = lo_out;
      end
    end
    check("midop_dones", 32'(dones), 32'd1);
    check("midop_hi", cap_hi, 32'd2);
    check("midop_lo", cap_lo, 32'd14);
    check("midop_hi_after", hi_out, 32'd2);

    // flush at cycle 10 of a MULT
    launch(2'b01, 32'hFFFF_FFFD, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_hi", hi_out, 32'd2);
    check("flush_lo", lo_out, 32'd14);

    // flush and start together: nothing launches
    flush = 1'b1;
    launch(2'b00, 32'd9, 32'd9);
    flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush_start_no_done", 32'(dones), 32'd0);
    check("flush_start_lo", lo_out, 32'd14);

    // asynchronous reset mid-DIV
    launch(2'b11, 32'hFFFF_FFF9, 32'd2);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi_out, 32'd0);
    check("arst_lo", lo_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("post_rst_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
